// File: rtl/spart_pkg.sv
// Shared constants, FSM state encoding and divisor arithmetic for the SPART
// echo controller.
package spart_pkg;

  localparam logic [1:0] IOADDR_DATA   = 2'b00;
  localparam logic [1:0] IOADDR_STATUS = 2'b01;
  localparam logic [1:0] IOADDR_DB_LO  = 2'b10;
  localparam logic [1:0] IOADDR_DB_HI  = 2'b11;

  typedef enum logic [2:0] {
    ST_CFG_WAIT = 3'd0,
    ST_CFG_LO   = 3'd1,
    ST_CFG_HI   = 3'd2,
    ST_IDLE     = 3'd3,
    ST_RD       = 3'd4,
    ST_WR       = 3'd5,
    ST_TX_GAP   = 3'd6
  } state_t;

  // Rounded clk / (16 * baud); 64-bit so large shifted baud rates cannot overflow.
  function automatic longint unsigned calc_divisor(input longint unsigned clk_hz,
                                                   input longint unsigned baud);
    return (clk_hz + 64'd8 * baud) / (64'd16 * baud);
  endfunction

endpackage

// File: rtl/spart_echo_ctrl_fifo.sv
// Byte FIFO for the echo path; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
module spart_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/spart_echo_ctrl.sv
// Bus-side SPART controller: programs the baud divisor from br_cfg and echoes
// received bytes back through a small FIFO.
module spart_echo_ctrl
  import spart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BASE_BAUD   = 4800,
  parameter int          CFG_W       = 2,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CFG_W-1:0]                br_cfg,
  output logic                            iocs,
  output logic                            iorw,
  output logic [1:0]                      ioaddr,
  input  logic                            rda,
  input  logic                            tbr,
  inout  wire  [7:0]                      databus,
  output logic                            cfg_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic [7:0]                      drop_cnt
);

  localparam int NCFG = 2 ** CFG_W;

  logic [NCFG-1:0][15:0] div_tab;

  for (genvar k = 0; k < NCFG; k++) begin : g_div
    localparam longint unsigned DIV =
      calc_divisor(64'(CLK_FREQ_HZ), 64'(BASE_BAUD) << k);
    if (DIV == 64'd0 || DIV > 64'hFFFF) begin : g_bad
      $error("spart_echo_ctrl: baud divisor out of 16-bit range");
    end
    assign div_tab[k] = 16'(DIV);
  end

  state_t             state;
  state_t             next_state;
  logic [CFG_W-1:0]   cfg_q;
  logic               cfg_change;
  logic [15:0]        divisor;
  logic [7:0]         wdata;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [7:0]         fifo_dout;

  assign cfg_change = (br_cfg != cfg_q);
  assign divisor    = div_tab[cfg_q];
  assign push       = (state == ST_RD) && !full;
  assign pop        = (state == ST_WR);

  spart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (databus),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CFG_WAIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_CFG_WAIT: if (tbr) next_state = ST_CFG_LO; else next_state = ST_CFG_WAIT;
      ST_CFG_LO:   next_state = ST_CFG_HI;
      ST_CFG_HI:   next_state = ST_IDLE;
      ST_IDLE: begin
        if (cfg_change)         next_state = ST_CFG_WAIT;
        else if (rda)           next_state = ST_RD;
        else if (!empty && tbr) next_state = ST_WR;
        else                    next_state = ST_IDLE;
      end
      ST_RD:       next_state = ST_IDLE;
      ST_WR:       next_state = ST_TX_GAP;
      ST_TX_GAP:   next_state = ST_IDLE;
      default:     next_state = ST_CFG_WAIT;
    endcase
  end

  always_comb begin
    iocs   = 1'b0;
    iorw   = 1'b1;
    ioaddr = IOADDR_DATA;
    wdata  = fifo_dout;
    case (state)
      ST_CFG_LO: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = IOADDR_DB_LO;
        wdata  = divisor[7:0];
      end
      ST_CFG_HI: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = IOADDR_DB_HI;
        wdata  = divisor[15:8];
      end
      ST_RD: begin
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = IOADDR_DATA;
      end
      ST_WR: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = IOADDR_DATA;
      end
      default: begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = IOADDR_DATA;
      end
    endcase
  end

  assign databus = (iocs && !iorw) ? wdata : 8'bz;

  // cfg_q only follows br_cfg when a reconfiguration is started, so a change
  // seen outside IDLE stays flagged until the FSM can act on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q    <= br_cfg;
      cfg_done <= 1'b0;
    end else if (state == ST_IDLE && cfg_change) begin
      cfg_q    <= br_cfg;
      cfg_done <= 1'b0;
    end else if (state == ST_CFG_HI) begin
      cfg_done <= 1'b1;
    end else begin
      cfg_done <= cfg_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else if (state == ST_RD && full && drop_cnt != 8'd255) begin
      drop_cnt <= drop_cnt + 8'd1;
    end else begin
      drop_cnt <= drop_cnt;
    end
  end

endmodule

// File: doc/spart_echo_ctrl.md
# spart_echo_ctrl

Parametrised bus-side controller for the SPART serial port. It programs the baud divisor from a board switch setting and re-programs it whenever the setting changes. Received bytes go into an internal FIFO and are echoed back through the SPART transmitter. It sits between the board I/O (switches, clock, reset) and the SPART `iocs`/`iorw`/`ioaddr`/`databus` processor interface, replacing a single-byte, unbuffered driver.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: system clock frequency.
- `BASE_BAUD`, 4800: baud rate for `br_cfg`=0; setting k selects `BASE_BAUD << k`.
- `CFG_W`, 2: width of `br_cfg`.
- `FIFO_DEPTH`, 8: echo buffer depth; power of two, ≥2.
- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `br_cfg` in `CFG_W`: baud select from switches.
- `iocs` out 1: SPART chip select.
- `iorw` out 1: 1 = read, 0 = write.
- `ioaddr` out 2: 00 data, 01 status, 10 divisor low, 11 divisor high.
- `rda` in 1: SPART receive data available.
- `tbr` in 1: SPART transmit buffer ready.
- `databus` inout 8: shared data bus.
- `cfg_done` out 1: divisor programmed for the current `br_cfg`.
- `fifo_level` out `$clog2(FIFO_DEPTH+1)`: current FIFO occupancy.
- `drop_cnt` out 8: count of received bytes dropped on overflow; saturates at 255.

## Operation
- Divisor: `(CLK_FREQ_HZ + 8*baud) / (16*baud)`, 16 bits. Elaboration fails if the result exceeds 0xFFFF or is 0. At default parameters: settings 0–3 give 651, 326, 163, 81.
- `br_cfg` is registered once into `cfg_q`. A change is flagged when `br_cfg != cfg_q`.
- Moore FSM; all bus outputs decode from the state register.
  - CFG_WAIT: wait until `tbr`=1, then go to CFG_LO.
  - CFG_LO: `iocs`=1, `iorw`=0, `ioaddr`=10, drive divisor[7:0]. Go to CFG_HI.
  - CFG_HI: `iocs`=1, `iorw`=0, `ioaddr`=11, drive divisor[15:8]. Go to IDLE.
  - IDLE: check conditions in priority order.
    - Change flagged: go to CFG_WAIT.
    - `rda`: go to RD.
    - FIFO non-empty and `tbr`: go to WR.
  - RD: `iocs`=1, `iorw`=1, `ioaddr`=00. Capture `databus` at the clock edge that ends the cycle. Push if the FIFO is not full; otherwise drop the byte and increment `drop_cnt`. Go to IDLE.
  - WR: `iocs`=1, `iorw`=0, `ioaddr`=00, drive the FIFO head. Pop at the end of the cycle. Go to TX_GAP.
  - TX_GAP: one cycle with `iocs`=0, during which `tbr` is ignored. Go to IDLE.
- A change detected in any state other than IDLE is acted on at the next IDLE. FIFO contents are preserved across reconfiguration.
- `cfg_done` clears on entry to CFG_WAIT and sets on the CFG_HI→IDLE transition.
- `databus` is driven only when `iocs`=1 and `iorw`=0; otherwise it is high-Z.
- Outside the bus-access states: `iocs`=0, `iorw`=1, `ioaddr`=00.

## Timing
- Reset values, in the cycle after `rst` is sampled high:
  - state CFG_WAIT; `iocs`=0, `iorw`=1, `ioaddr`=00.
  - `cfg_done`=0, `fifo_level`=0, `drop_cnt`=0.
  - `cfg_q` loaded with `br_cfg`.
- Reset mid-operation aborts any bus cycle immediately and empties the FIFO.
- Configuration: if `tbr`=1 at reset release, CFG_LO occurs in cycle 1, CFG_HI in cycle 2, and `cfg_done`=1 from cycle 3.
- Echo latency: `rda` seen in IDLE at cycle n gives RD at n+1, IDLE at n+2, and WR at n+3 if `tbr`=1.
- `rda` and a WR-eligible FIFO in the same IDLE cycle: RD wins.
- Full FIFO plus `rda`: the bus read still occurs, so the SPART buffer is drained, but the byte is discarded.
- `drop_cnt` holds at 255.
- A FIFO push and pop never occur in the same cycle, because RD and WR are exclusive states.

## Structure
- `spart_pkg` holds:
  - `ioaddr` constants `IOADDR_DATA`, `IOADDR_STATUS`, `IOADDR_DB_LO`, `IOADDR_DB_HI`.
  - the FSM state enum.
  - function `calc_divisor(clk_hz, baud)`.
- Sub-module `spart_byte_fifo`:
  - parameter DEPTH; 8-bit data.
  - ports push, pop, din, dout, full, empty, level.
  - synchronous active-high reset.
  - wrap-around pointers with one extra bit.

## Test plan
- Reset, `br_cfg`=00, `tbr`=1 -> write 0x8B to `ioaddr` 10, then 0x02 to 11 (651); `cfg_done`=1 in cycle 3.
- `br_cfg`=11 -> divisor writes 0x51 then 0x00 (81).
- In IDLE, `rda` pulse with `databus`=0x41, `tbr`=1 -> RD at n+1, WR of 0x41 on `ioaddr` 00 at n+3, then TX_GAP.
- `tbr`=0, 9 received bytes 0x01–0x09 -> `fifo_level`=8, `drop_cnt`=1; raise `tbr` -> 0x01–0x08 transmitted in order, one WR every 3 cycles.
- FIFO holds 2 bytes, `br_cfg` goes 00→01 -> `cfg_done` drops, 0x46/0x01 written (326), then both bytes echoed.
- `rst` asserted during WR -> next cycle `iocs`=0, `databus` high-Z, `fifo_level`=0, state CFG_WAIT.
